// File: rtl/commit_tracker_if.sv
// commit_tracker_if
//   Groups the MPU issue bus, the per-TPU commit strobes and the aggregated
//   commit/status outputs of commit_tracker.
//   master : driven by the MPU/TPU side (issues and per-TPU commits),
//            observes aggregated commits and status.
//   slave  : the tracker itself.
//   Signals:
//     I_Req, I_Issue_No, I_En_TPU     thread issue strobe, number, TPU mask
//     I_Commit_Req, I_Commit_No       per-TPU termination strobe and number
//                                     (TPU t uses I_Commit_No[t*ISSUE_W +: ISSUE_W])
//     O_Commit_Req, O_Commit_No       aggregated in-order commit pulse
//     O_Full, O_Empty, O_Err          buffer status and sticky error flag
interface commit_tracker_if #(
   parameter int NUM_TPU = 16,
   parameter int ISSUE_W = 8
);
   logic                       I_Req;
   logic [ISSUE_W-1:0]         I_Issue_No;
   logic [NUM_TPU-1:0]         I_En_TPU;
   logic [NUM_TPU-1:0]         I_Commit_Req;
   logic [NUM_TPU*ISSUE_W-1:0] I_Commit_No;
   logic                       O_Commit_Req;
   logic [ISSUE_W-1:0]         O_Commit_No;
   logic                       O_Full;
   logic                       O_Empty;
   logic                       O_Err;

   modport master (
      output I_Req, I_Issue_No, I_En_TPU, I_Commit_Req, I_Commit_No,
      input  O_Commit_Req, O_Commit_No, O_Full, O_Empty, O_Err
   );

   modport slave (
      input  I_Req, I_Issue_No, I_En_TPU, I_Commit_Req, I_Commit_No,
      output O_Commit_Req, O_Commit_No, O_Full, O_Empty, O_Err
   );
endinterface

// File: rtl/commit_tracker.sv
// commit_tracker
//   In-order commit tracker between the TPU array and the MPU. Each issued
//   thread is stored in a circular buffer with the mask of TPUs that run it.
//   Per-TPU termination commits (any order, several per cycle) clear bits of
//   that mask; the head entry retires as one aggregated commit once its mask
//   is empty, so commits reach the MPU strictly in issue order.
//
//   Ports:
//     clock  system clock, all state on the rising edge
//     reset  synchronous active-high clear of all state
//     bus    commit_tracker_if.slave (issue, per-TPU commits, aggregated
//            commit, O_Full/O_Empty/O_Err)
//
//   Optional feature: define COMMIT_TRACKER_ERR_EN to build the sticky
//   protocol error flag O_Err (issue while full, unmatched commit, commit to
//   an already-cleared pending bit). Without it O_Err is tied low.
module commit_tracker #(
   parameter int NUM_TPU   = 16,
   parameter int BUFF_SIZE = 8,
   parameter int ISSUE_W   = 8
) (
   input  logic             clock,
   input  logic             reset,
   commit_tracker_if.slave  bus
);
   localparam int PTR_W = $clog2(BUFF_SIZE);
   localparam int CNT_W = $clog2(BUFF_SIZE + 1);

   // Buffer state
   logic [BUFF_SIZE-1:0] valid_reg;
   logic [ISSUE_W-1:0]   issue_no_reg [BUFF_SIZE];
   logic [NUM_TPU-1:0]   pending_reg  [BUFF_SIZE];
   logic [PTR_W-1:0]     head_reg;
   logic [PTR_W-1:0]     tail_reg;
   logic [CNT_W-1:0]     count_reg;
   logic                 commit_req_reg;
   logic [ISSUE_W-1:0]   commit_no_reg;

   // Per-TPU commit number unpacked from the flat bus
   logic [ISSUE_W-1:0]   commit_no [NUM_TPU];

   // hit[t][e]: TPU t clears its bit in entry e this cycle
   logic [NUM_TPU-1:0][BUFF_SIZE-1:0] hit;
   // clr[e][t]: same information indexed by entry first
   logic [BUFF_SIZE-1:0][NUM_TPU-1:0] clr;

   logic                 match_found;
   logic [PTR_W-1:0]     match_idx;
   logic [PTR_W-1:0]     scan_ptr;

   logic                 full;
   logic                 empty;
   logic                 issue_acc;
   logic                 head_done;

   generate
      for (genvar gi = 0; gi < NUM_TPU; gi++) begin : g_unpack
         assign commit_no[gi] = bus.I_Commit_No[gi*ISSUE_W +: ISSUE_W];
      end
      for (genvar gi = 0; gi < BUFF_SIZE; gi++) begin : g_entry
         for (genvar gj = 0; gj < NUM_TPU; gj++) begin : g_tpu
            assign clr[gi][gj] = hit[gj][gi];
         end
      end
   endgenerate

   assign full      = (count_reg == CNT_W'(BUFF_SIZE));
   assign empty     = (count_reg == '0);
   assign issue_acc = bus.I_Req && !full;
   // Retire decision uses registered pending bits only, so the last clearing
   // commit in cycle N lets the entry retire at the end of N+1.
   assign head_done = valid_reg[head_reg] && (pending_reg[head_reg] == '0);

   // Commit matching: for each TPU find the oldest valid entry carrying the
   // committed issue number. The scan runs youngest to oldest so the last
   // hit overwrites the others and the oldest one wins. Only entries valid
   // at cycle start take part, so an entry written this cycle never matches.
   always_comb begin
      hit         = '0;
      match_found = 1'b0;
      match_idx   = '0;
      scan_ptr    = '0;
      for (int t = 0; t < NUM_TPU; t++) begin
         match_found = 1'b0;
         match_idx   = '0;
         for (int k = BUFF_SIZE - 1; k >= 0; k--) begin
            scan_ptr = head_reg + k[PTR_W-1:0];
            if (valid_reg[scan_ptr] && (issue_no_reg[scan_ptr] == commit_no[t])) begin
               match_found = 1'b1;
               match_idx   = scan_ptr;
            end
         end
         if (bus.I_Commit_Req[t] && match_found) begin
            hit[t][match_idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_reg      <= '0;
         head_reg       <= '0;
         tail_reg       <= '0;
         count_reg      <= '0;
         commit_req_reg <= 1'b0;
         commit_no_reg  <= '0;
         for (int e = 0; e < BUFF_SIZE; e++) begin
            issue_no_reg[e] <= '0;
            pending_reg[e]  <= '0;
         end
      end else begin
         // Clearing an already-clear bit is harmless, so unmatched or stale
         // commits need no special handling here.
         for (int e = 0; e < BUFF_SIZE; e++) begin
            pending_reg[e] <= pending_reg[e] & ~clr[e];
         end

         if (head_done) begin
            valid_reg[head_reg] <= 1'b0;
            head_reg            <= head_reg + PTR_W'(1);
         end

         // An accepted issue never targets a valid slot (tail == head only
         // when empty or full, and full refuses the issue), so this write
         // cannot collide with the clear or retire above.
         if (issue_acc) begin
            valid_reg[tail_reg]    <= 1'b1;
            issue_no_reg[tail_reg] <= bus.I_Issue_No;
            pending_reg[tail_reg]  <= bus.I_En_TPU;
            tail_reg               <= tail_reg + PTR_W'(1);
         end

         commit_req_reg <= head_done;
         if (head_done) begin
            commit_no_reg <= issue_no_reg[head_reg];
         end

         case ({issue_acc, head_done})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign bus.O_Commit_Req = commit_req_reg;
   assign bus.O_Commit_No  = commit_no_reg;
   assign bus.O_Full       = full;
   assign bus.O_Empty      = empty;

`ifdef COMMIT_TRACKER_ERR_EN
   logic               err_reg;
   logic [NUM_TPU-1:0] miss;
   logic [NUM_TPU-1:0] stale;

   // miss: commit strobe with no matching entry at all.
   // stale: matched entry whose bit for this TPU is already clear.
   always_comb begin
      miss  = '0;
      stale = '0;
      for (int t = 0; t < NUM_TPU; t++) begin
         miss[t] = bus.I_Commit_Req[t] && (hit[t] == '0);
         for (int e = 0; e < BUFF_SIZE; e++) begin
            if (hit[t][e] && !pending_reg[e][t]) begin
               stale[t] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         err_reg <= 1'b0;
      end else if ((bus.I_Req && full) || (miss != '0) || (stale != '0)) begin
         err_reg <= 1'b1;
      end
   end

   assign bus.O_Err = err_reg;
`else
   assign bus.O_Err = 1'b0;
`endif

endmodule

// File: tb/tb_commit_tracker.sv
// tb_commit_tracker
//   Self-checking bench for commit_tracker: table-driven vectors for the
//   basic sequences, hand-written sequences for full/reset corners, and a
//   randomized run checked every cycle against a queue-based model.
module tb_commit_tracker;
   localparam int NUM_TPU   = 16;
   localparam int BUFF_SIZE = 8;
   localparam int ISSUE_W   = 8;
`ifdef COMMIT_TRACKER_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   localparam bit H = 1'b1;
   localparam bit L = 1'b0;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   commit_tracker_if #(.NUM_TPU(NUM_TPU), .ISSUE_W(ISSUE_W)) bus ();

   commit_tracker #(
      .NUM_TPU  (NUM_TPU),
      .BUFF_SIZE(BUFF_SIZE),
      .ISSUE_W  (ISSUE_W)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   int errors = 0;
   int checks = 0;

   // ---------------- reference model ----------------
   typedef struct {
      logic [7:0]  issue_no;
      logic [15:0] pending;
   } ent_t;

   ent_t       mq[$];
   logic       m_creq = 1'b0;
   logic [7:0] m_cno  = 8'h00;
   logic       m_err  = 1'b0;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0b required=%0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%02h required=0x%02h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock edge of the tracker, described as queue operations.
   task automatic model_edge();
      int   nq;
      bit   ret;
      int   hitq;
      ent_t e;
      logic [7:0] cn;
      if (reset) begin
         mq.delete();
         m_creq = 1'b0;
         m_cno  = 8'h00;
         m_err  = 1'b0;
         return;
      end
      nq  = mq.size();
      ret = (nq > 0) && (mq[0].pending == 16'h0000);
      for (int t = 0; t < NUM_TPU; t++) begin
         if (bus.I_Commit_Req[t]) begin
            cn   = bus.I_Commit_No[t*ISSUE_W +: ISSUE_W];
            hitq = -1;
            for (int i = 0; i < nq; i++) begin
               if (hitq < 0 && mq[i].issue_no == cn) hitq = i;
            end
            if (hitq < 0) begin
               m_err = m_err | ERR_EN;
            end else if (!mq[hitq].pending[t]) begin
               m_err = m_err | ERR_EN;
            end else begin
               e = mq[hitq];
               e.pending[t] = 1'b0;
               mq[hitq] = e;
            end
         end
      end
      if (bus.I_Req) begin
         if (nq == BUFF_SIZE) begin
            m_err = m_err | ERR_EN;
         end else begin
            e.issue_no = bus.I_Issue_No;
            e.pending  = bus.I_En_TPU;
            mq.push_back(e);
         end
      end
      m_creq = ret;
      if (ret) begin
         m_cno = mq[0].issue_no;
         void'(mq.pop_front());
      end
   endtask

   task automatic model_check();
      chk1("m_full",  bus.O_Full,  mq.size() == BUFF_SIZE);
      chk1("m_empty", bus.O_Empty, mq.size() == 0);
      chk1("m_creq",  bus.O_Commit_Req, m_creq);
      if (m_creq) chk8("m_cno", bus.O_Commit_No, m_cno);
      chk1("m_err",   bus.O_Err, m_err);
   endtask

   // Inputs are set before calling; model advances at the edge, DUT outputs
   // are compared on the falling edge.
   task automatic step();
      @(posedge clock);
      model_edge();
      @(negedge clock);
      model_check();
   endtask

   task automatic idle_inputs();
      bus.I_Req        = 1'b0;
      bus.I_Issue_No   = 8'h00;
      bus.I_En_TPU     = 16'h0000;
      bus.I_Commit_Req = 16'h0000;
      bus.I_Commit_No  = '0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit         rst;
      bit         req;
      logic [7:0] ino;
      logic [15:0] en;
      logic [15:0] creq;
      logic [7:0] cno;
      bit         e_creq;
      logic [7:0] e_cno;
      bit         e_full;
      bit         e_empty;
      bit         e_err;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(bit rst, bit req, logic [7:0] ino, logic [15:0] en,
                              logic [15:0] creq, logic [7:0] cno, bit ecr,
                              logic [7:0] ecno, bit ef, bit ee, bit eerr);
      vec_t r;
      r.rst = rst; r.req = req; r.ino = ino; r.en = en; r.creq = creq; r.cno = cno;
      r.e_creq = ecr; r.e_cno = ecno; r.e_full = ef; r.e_empty = ee; r.e_err = eerr;
      return r;
   endfunction

   logic [7:0] rnd_no;

   initial begin
      idle_inputs();

      // Out-of-order commits from TPU3,1,0,2 on 0x05, mask 0x000F
      tbl.push_back(v(H, L, 8'h00, 16'h0000, 16'h0000, 8'h00, L, 8'h00, L, H, L));
      tbl.push_back(v(L, H, 8'h05, 16'h000F, 16'h0000, 8'h00, L, 8'h00, L, L, L));
      tbl.push_back(v(L, L, 8'h00, 16'h0000, 16'h0008, 8'h05, L, 8'h00, L, L, L));
      tbl.push_back(v(L, L, 8'h00, 16'h0000, 16'h0002, 8'h05, L, 8'h00, L, L, L));
      tbl.push_back(v(L, L, 8'h00, 16'h0000, 16'h0001, 8'h05, L, 8'h00, L, L, L));
      tbl.push_back(v(L, L, 8'h00, 16'h0000, 16'h0004, 8'h05, L, 8'h00, L, L, L));
      tbl.push_back(v(L, L, 8'h00, 16'h0000, 16'h0000, 8'h00, H, 8'h05, L, H, L));
      tbl.push_back(v(L, L, 8'h00, 16'h0000, 16'h0000, 8'h00, L, 8'h00, L, H, L));
      // Younger completes first; retires stay in issue order
      tbl.push_back(v(H, L, 8'h00, 16'h0000, 16'h0000, 8'h00, L, 8'h00, L, H, L));
      tbl.push_back(v(L, H, 8'h10, 16'h0001, 16'h0000, 8'h00, L, 8'h00, L, L, L));
      tbl.push_back(v(L, H, 8'h11, 16'h0002, 16'h0000, 8'h00, L, 8'h00, L, L, L));
      tbl.push_back(v(L, L, 8'h00, 16'h0000, 16'h0002, 8'h11, L, 8'h00, L, L, L));
      tbl.push_back(v(L, L, 8'h00, 16'h0000, 16'h0000, 8'h00, L, 8'h00, L, L, L));
      tbl.push_back(v(L, L, 8'h00, 16'h0000, 16'h0000, 8'h00, L, 8'h00, L, L, L));
      tbl.push_back(v(L, L, 8'h00, 16'h0000, 16'h0001, 8'h10, L, 8'h00, L, L, L));
      tbl.push_back(v(L, L, 8'h00, 16'h0000, 16'h0000, 8'h00, H, 8'h10, L, L, L));
      tbl.push_back(v(L, L, 8'h00, 16'h0000, 16'h0000, 8'h00, H, 8'h11, L, H, L));
      tbl.push_back(v(L, L, 8'h00, 16'h0000, 16'h0000, 8'h00, L, 8'h00, L, H, L));
      // All 16 TPUs commit in one cycle
      tbl.push_back(v(H, L, 8'h00, 16'h0000, 16'h0000, 8'h00, L, 8'h00, L, H, L));
      tbl.push_back(v(L, H, 8'h30, 16'hFFFF, 16'h0000, 8'h00, L, 8'h00, L, L, L));
      tbl.push_back(v(L, L, 8'h00, 16'h0000, 16'hFFFF, 8'h30, L, 8'h00, L, L, L));
      tbl.push_back(v(L, L, 8'h00, 16'h0000, 16'h0000, 8'h00, H, 8'h30, L, H, L));
      tbl.push_back(v(L, L, 8'h00, 16'h0000, 16'h0000, 8'h00, L, 8'h00, L, H, L));
      // Unmatched commit on empty buffer, then a zero-mask issue
      tbl.push_back(v(H, L, 8'h00, 16'h0000, 16'h0000, 8'h00, L, 8'h00, L, H, L));
      tbl.push_back(v(L, L, 8'h00, 16'h0000, 16'h0001, 8'h7F, L, 8'h00, L, H, ERR_EN));
      tbl.push_back(v(L, L, 8'h00, 16'h0000, 16'h0000, 8'h00, L, 8'h00, L, H, ERR_EN));
      tbl.push_back(v(L, H, 8'h44, 16'h0000, 16'h0000, 8'h00, L, 8'h00, L, L, ERR_EN));
      tbl.push_back(v(L, L, 8'h00, 16'h0000, 16'h0000, 8'h00, H, 8'h44, L, H, ERR_EN));
      tbl.push_back(v(L, L, 8'h00, 16'h0000, 16'h0000, 8'h00, L, 8'h00, L, H, ERR_EN));

      foreach (tbl[i]) begin
         reset            = tbl[i].rst;
         bus.I_Req        = tbl[i].req;
         bus.I_Issue_No   = tbl[i].ino;
         bus.I_En_TPU     = tbl[i].en;
         bus.I_Commit_Req = tbl[i].creq;
         for (int t = 0; t < NUM_TPU; t++) bus.I_Commit_No[t*ISSUE_W +: ISSUE_W] = tbl[i].cno;
         step();
         chk1("tbl_creq",  bus.O_Commit_Req, tbl[i].e_creq);
         if (tbl[i].e_creq) chk8("tbl_cno", bus.O_Commit_No, tbl[i].e_cno);
         if (tbl[i].rst)    chk8("tbl_rst_cno", bus.O_Commit_No, 8'h00);
         chk1("tbl_full",  bus.O_Full,  tbl[i].e_full);
         chk1("tbl_empty", bus.O_Empty, tbl[i].e_empty);
         chk1("tbl_err",   bus.O_Err,   tbl[i].e_err);
         $display("vec %0d: creq=%0b cno=0x%02h full=%0b empty=%0b err=%0b",
                  i, bus.O_Commit_Req, bus.O_Commit_No, bus.O_Full, bus.O_Empty, bus.O_Err);
      end
      idle_inputs();
      reset = 1'b0;

      // ---- Fill to full, dropped 9th issue, refused issue during retire ----
      reset = 1'b1; step(); reset = 1'b0;
      for (int i = 0; i < BUFF_SIZE; i++) begin
         bus.I_Req      = 1'b1;
         bus.I_Issue_No = 8'h20 + 8'(i);
         bus.I_En_TPU   = 16'h0001 << i;
         step();
      end
      chk1("full8", bus.O_Full, 1'b1);
      bus.I_Issue_No = 8'h28;
      bus.I_En_TPU   = 16'h0000;
      step();
      chk1("full_drop", bus.O_Full, 1'b1);
      chk1("full_err",  bus.O_Err,  ERR_EN);
      bus.I_Req = 1'b0;
      bus.I_Commit_Req = 16'h00FF;
      for (int t = 0; t < BUFF_SIZE; t++) bus.I_Commit_No[t*ISSUE_W +: ISSUE_W] = 8'h20 + 8'(t);
      step();
      idle_inputs();
      // Head retires during this cycle while still full: issue is refused
      bus.I_Req      = 1'b1;
      bus.I_Issue_No = 8'h50;
      for (int k = 0; k < BUFF_SIZE; k++) begin
         step();
         bus.I_Req = 1'b0;
         chk1("drain_creq", bus.O_Commit_Req, 1'b1);
         chk8("drain_cno",  bus.O_Commit_No, 8'h20 + 8'(k));
         if (k == 0) chk1("drain_full", bus.O_Full, 1'b0);
         $display("drain %0d: cno=0x%02h", k, bus.O_Commit_No);
      end
      chk1("drain_empty", bus.O_Empty, 1'b1);
      step();
      chk1("drain_end", bus.O_Commit_Req, 1'b0);

      // ---- Reset with three outstanding entries ----
      reset = 1'b1; step(); reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.I_Req      = 1'b1;
         bus.I_Issue_No = 8'h60 + 8'(i);
         bus.I_En_TPU   = 16'h0001;
         step();
      end
      idle_inputs();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk1("rst_empty", bus.O_Empty, 1'b1);
      chk1("rst_full",  bus.O_Full,  1'b0);
      chk1("rst_creq",  bus.O_Commit_Req, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk1("rst_quiet", bus.O_Commit_Req, 1'b0);
      end
      bus.I_Req      = 1'b1;
      bus.I_Issue_No = 8'h01;
      bus.I_En_TPU   = 16'h0000;
      step();
      idle_inputs();
      chk1("rst_zm_n1", bus.O_Commit_Req, 1'b0);
      step();
      chk1("rst_zm_n2", bus.O_Commit_Req, 1'b1);
      chk8("rst_zm_no", bus.O_Commit_No, 8'h01);
      $display("reset seq: retired 0x%02h", bus.O_Commit_No);

      // ---- Randomized run against the model ----
      for (int c = 0; c < 4000; c++) begin
         reset          = ($urandom_range(0, 299) == 0);
         bus.I_Req      = ($urandom_range(0, 9) < 5);
         bus.I_Issue_No = 8'($urandom_range(0, 15));
         bus.I_En_TPU   = 16'($urandom & $urandom & $urandom);
         for (int t = 0; t < NUM_TPU; t++) begin
            bus.I_Commit_Req[t] = ($urandom_range(0, 3) == 0);
            if (mq.size() > 0 && $urandom_range(0, 9) < 8)
               rnd_no = mq[$urandom_range(0, mq.size() - 1)].issue_no;
            else
               rnd_no = 8'($urandom_range(0, 31));
            bus.I_Commit_No[t*ISSUE_W +: ISSUE_W] = rnd_no;
         end
         step();
      end
      reset = 1'b0;
      idle_inputs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
